// File: rtl/adc_model_multi_if.sv
// Reader-to-ADC-model bundle: chip select, serial clock, waveform controls
// and the per-channel serial data / frame status coming back.
interface adc_model_multi_if #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 1
);
    logic                      run;
    logic [1:0]                mode;
    logic [WIDTH-1:0]          const_val;
    logic                      cs;
    logic                      sclk;
    logic [CHANNELS-1:0]       sd;
    logic                      done;
    logic                      short_frame;
    logic [CHANNELS*WIDTH-1:0] sample_dbg;

    modport master (
        output run, mode, const_val, cs, sclk,
        input  sd, done, short_frame, sample_dbg
    );

    modport slave (
        input  run, mode, const_val, cs, sclk,
        output sd, done, short_frame, sample_dbg
    );
endinterface

// File: rtl/adc_model_multi.sv
// Behavioural multi-channel serial SAR ADC model: free-running waveform
// generator, per-channel shadow latch at frame start, MSB-first shift-out.
module adc_model_multi #(
    parameter int WIDTH      = 12,
    parameter int CHANNELS   = 1,
    parameter int LEAD_ZEROS = 1,
    parameter int PERIOD     = 10,
    parameter int STEP       = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    adc_model_multi_if.slave  bus
);
    localparam int TIMER_W    = (PERIOD > 0) ? $clog2(PERIOD + 1) : 1;
    localparam int CNT_W      = 5;
    localparam int FRAME_LAST = LEAD_ZEROS + WIDTH - 1;
    localparam int FLAT_W     = CHANNELS * WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    logic [TIMER_W-1:0] timer_r;
    logic [WIDTH-1:0]   ramp_r;
    logic [WIDTH-1:0]   tri_r;
    logic               tri_up_r;
    logic [15:0]        lfsr_r;
    logic               update_s;

    state_t             state_r, state_nx;
    logic [CNT_W-1:0]   bit_cnt_r, bit_cnt_nx;
    logic [FLAT_W-1:0]  shadow_r, shadow_nx;
    logic [FLAT_W-1:0]  dbg_r, dbg_nx;
    logic [FLAT_W-1:0]  chan_val_s;
    logic [CHANNELS-1:0] sd_r, sd_nx;
    logic               done_r, done_nx;
    logic               short_r, short_nx;
    logic               cs_d_r, sclk_d_r;
    logic               fall_cs_s, rise_cs_s, fall_sclk_s;

    function automatic logic [WIDTH-1:0] rotl_w(input logic [WIDTH-1:0] v, input int n);
        logic [2*WIDTH-1:0] dbl;
        dbl = {v, v} << n;
        return dbl[2*WIDTH-1 -: WIDTH];
    endfunction

    assign update_s    = (timer_r == TIMER_W'(PERIOD));
    assign fall_cs_s   = cs_d_r & ~bus.cs;
    assign rise_cs_s   = ~cs_d_r & bus.cs;
    assign fall_sclk_s = sclk_d_r & ~bus.sclk;

    // Free-running generator: timer, ramp base, triangle and LFSR
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_r  <= {TIMER_W{1'b0}};
            ramp_r   <= {WIDTH{1'b0}};
            tri_r    <= {WIDTH{1'b0}};
            tri_up_r <= 1'b1;
            lfsr_r   <= 16'hACE1;
        end else if (update_s) begin
            timer_r <= {TIMER_W{1'b0}};
            ramp_r  <= ramp_r + WIDTH'(STEP);
            // Each extreme is held for one update, then the counter steps back
            if (tri_up_r) begin
                if (tri_r == {WIDTH{1'b1}}) begin
                    tri_r    <= tri_r - WIDTH'(1);
                    tri_up_r <= 1'b0;
                end else begin
                    tri_r <= tri_r + WIDTH'(1);
                end
            end else begin
                if (tri_r == {WIDTH{1'b0}}) begin
                    tri_r    <= WIDTH'(1);
                    tri_up_r <= 1'b1;
                end else begin
                    tri_r <= tri_r - WIDTH'(1);
                end
            end
            lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
        end else begin
            timer_r <= timer_r + TIMER_W'(1);
        end
    end

    // Per-channel view of the generator for the selected waveform
    always_comb begin
        chan_val_s = {FLAT_W{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            case (bus.mode)
                2'd0:    chan_val_s[c*WIDTH +: WIDTH] = ramp_r + WIDTH'(c);
                2'd1:    chan_val_s[c*WIDTH +: WIDTH] = tri_r;
                2'd2:    chan_val_s[c*WIDTH +: WIDTH] = rotl_w(lfsr_r[WIDTH-1:0], c % WIDTH);
                2'd3:    chan_val_s[c*WIDTH +: WIDTH] = bus.const_val;
                default: chan_val_s[c*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            endcase
        end
    end

    // Frame FSM next state: run and rise_cs override any sclk activity
    always_comb begin
        state_nx   = state_r;
        bit_cnt_nx = bit_cnt_r;
        shadow_nx  = shadow_r;
        dbg_nx     = dbg_r;
        sd_nx      = sd_r;
        done_nx    = 1'b0;
        short_nx   = 1'b0;
        if (!bus.run) begin
            state_nx   = ST_IDLE;
            bit_cnt_nx = {CNT_W{1'b0}};
            sd_nx      = {CHANNELS{1'b0}};
        end else if (rise_cs_s) begin
            state_nx   = ST_IDLE;
            bit_cnt_nx = {CNT_W{1'b0}};
            sd_nx      = {CHANNELS{1'b0}};
            done_nx    = (state_r == ST_TAIL);
            short_nx   = (state_r == ST_SHIFT);
        end else begin
            case (state_r)
                ST_IDLE: begin
                    sd_nx = {CHANNELS{1'b0}};
                    if (fall_cs_s) begin
                        shadow_nx  = chan_val_s;
                        dbg_nx     = chan_val_s;
                        bit_cnt_nx = {CNT_W{1'b0}};
                        state_nx   = ST_SHIFT;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (fall_sclk_s) begin
                        // Shadow doubles as a shift register: MSB goes out first
                        if (bit_cnt_r < CNT_W'(LEAD_ZEROS)) begin
                            sd_nx = {CHANNELS{1'b0}};
                        end else begin
                            for (int c = 0; c < CHANNELS; c++) begin
                                sd_nx[c] = shadow_r[c*WIDTH + WIDTH - 1];
                                shadow_nx[c*WIDTH +: WIDTH] = {shadow_r[c*WIDTH +: (WIDTH-1)], 1'b0};
                            end
                        end
                        bit_cnt_nx = bit_cnt_r + CNT_W'(1);
                        if (bit_cnt_r == CNT_W'(FRAME_LAST)) begin
                            state_nx = ST_TAIL;
                        end else begin
                            state_nx = ST_SHIFT;
                        end
                    end else begin
                        state_nx = ST_SHIFT;
                    end
                end
                ST_TAIL: begin
                    if (fall_sclk_s) begin
                        sd_nx = {CHANNELS{1'b0}};
                    end else begin
                        sd_nx = sd_r;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    sd_nx    = {CHANNELS{1'b0}};
                end
            endcase
        end
    end

    // Frame state, edge history and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= {CNT_W{1'b0}};
            shadow_r  <= {FLAT_W{1'b0}};
            dbg_r     <= {FLAT_W{1'b0}};
            sd_r      <= {CHANNELS{1'b0}};
            done_r    <= 1'b0;
            short_r   <= 1'b0;
            cs_d_r    <= 1'b1;
            sclk_d_r  <= 1'b0;
        end else begin
            state_r   <= state_nx;
            bit_cnt_r <= bit_cnt_nx;
            shadow_r  <= shadow_nx;
            dbg_r     <= dbg_nx;
            sd_r      <= sd_nx;
            done_r    <= done_nx;
            short_r   <= short_nx;
            cs_d_r    <= bus.cs;
            sclk_d_r  <= bus.sclk;
        end
    end

    assign bus.sd          = sd_r;
    assign bus.done        = done_r;
    assign bus.short_frame = short_r;
    assign bus.sample_dbg  = dbg_r;
endmodule

// File: tb/tb_adc_model_multi.sv
// Randomised bench for adc_model_multi: a frame-level reference model predicts
// every cycle's outputs into a queue that a separate monitor drains.
module tb_adc_model_multi;
    localparam int W    = 6;
    localparam int CH   = 3;
    localparam int LZ   = 2;
    localparam int PER  = 2;
    localparam int STP  = 3;
    localparam int FLEN = LZ + W;

    logic clk = 1'b0;
    logic reset_n;

    adc_model_multi_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

    adc_model_multi #(
        .WIDTH(W), .CHANNELS(CH), .LEAD_ZEROS(LZ), .PERIOD(PER), .STEP(STP)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CH-1:0]   sd;
        logic            done;
        logic            shrt;
        logic [CH*W-1:0] dbg;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // reference model state
    int              gen_k;
    bit              active;
    int              nfall;
    logic [W-1:0]    lat[CH];
    logic [CH-1:0]   m_sd;
    logic [CH*W-1:0] m_dbg;
    bit              cs_prev, sclk_prev;
    logic [15:0]     lfsr_hist[$];

    function automatic logic [15:0] lfsr_at(int u);
        logic [15:0] s;
        while (lfsr_hist.size() <= u) begin
            s = lfsr_hist[lfsr_hist.size() - 1];
            lfsr_hist.push_back({s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]});
        end
        return lfsr_hist[u];
    endfunction

    // value channel c would present after k generator clocks since reset
    function automatic logic [W-1:0] chan_value(int k, logic [1:0] md, logic [W-1:0] cv, int c);
        int u, m, p;
        logic [15:0] l16;
        logic [W-1:0] r;
        u = k / (PER + 1);
        m = (1 << W) - 1;
        r = '0;
        case (md)
            2'd0: r = W'(u * STP + c);
            2'd1: begin
                p = u % (2 * m);
                r = W'((p <= m) ? p : 2 * m - p);
            end
            2'd2: begin
                l16 = lfsr_at(u);
                for (int i = 0; i < W; i++) r[(i + c) % W] = l16[i];
            end
            default: r = cv;
        endcase
        return r;
    endfunction

    task automatic model_edge();
        exp_t e;
        bit fcs, rcs, fsc;
        e.done = 1'b0;
        e.shrt = 1'b0;
        if (!reset_n) begin
            gen_k = 0; active = 0; nfall = 0;
            m_sd = '0; m_dbg = '0; cs_prev = 1; sclk_prev = 0;
        end else begin
            fcs = cs_prev && !bus.cs;
            rcs = !cs_prev && bus.cs;
            fsc = sclk_prev && !bus.sclk;
            if (!bus.run) begin
                active = 0; m_sd = '0;
            end else if (rcs) begin
                if (active) begin
                    if (nfall >= FLEN) e.done = 1'b1;
                    else e.shrt = 1'b1;
                end
                active = 0; m_sd = '0;
            end else if (active) begin
                if (fsc) begin
                    for (int c = 0; c < CH; c++) begin
                        if (nfall < LZ || nfall >= FLEN) m_sd[c] = 1'b0;
                        else m_sd[c] = lat[c][W - 1 - (nfall - LZ)];
                    end
                    nfall++;
                end
            end else if (fcs) begin
                for (int c = 0; c < CH; c++) begin
                    lat[c] = chan_value(gen_k, bus.mode, bus.const_val, c);
                    m_dbg[c*W +: W] = lat[c];
                end
                active = 1; nfall = 0;
            end
            cs_prev = bus.cs;
            sclk_prev = bus.sclk;
            gen_k++;
        end
        e.sd = m_sd;
        e.dbg = m_dbg;
        exp_q.push_back(e);
    endtask

    task automatic cycle(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task automatic sclk_falls(int nf, int half);
        repeat (nf) begin
            bus.sclk = 1'b0; cycle(half);
            bus.sclk = 1'b1; cycle(half);
        end
    endtask

    task automatic frame(int nf, int half);
        bus.cs = 1'b0; cycle(half);
        sclk_falls(nf, half);
        bus.cs = 1'b1; cycle(half);
    endtask

    // Monitor: one predicted record per clock, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (bus.sd !== e.sd || bus.done !== e.done || bus.short_frame !== e.shrt
                || bus.sample_dbg !== e.dbg) begin
                bad++;
                $display("FAIL outputs t=%0t got sd=%b done=%b short=%b dbg=%h, want sd=%b done=%b short=%b dbg=%h",
                         $time, bus.sd, bus.done, bus.short_frame, bus.sample_dbg,
                         e.sd, e.done, e.shrt, e.dbg);
            end
        end
    end

    initial begin
        lfsr_hist.push_back(16'hACE1);
        reset_n = 1'b0;
        bus.run = 1'b0; bus.mode = 2'd0; bus.const_val = '0;
        bus.cs = 1'b1; bus.sclk = 1'b1;
        cycle(3);
        reset_n = 1'b1; bus.run = 1'b1;
        cycle(4);

        // complete ramp and constant frames
        frame(FLEN, 2);
        bus.mode = 2'd3; bus.const_val = 6'h2B; cycle(2);
        frame(FLEN, 3);
        frame(FLEN + 2, 2);

        // short frame then a fresh frame
        bus.mode = 2'd3; bus.const_val = 6'h3F;
        frame(6, 2);
        frame(FLEN, 2);

        // rise_cs together with the LSB fall, and together with a data fall
        bus.cs = 1'b0; cycle(2);
        sclk_falls(FLEN - 1, 2);
        bus.cs = 1'b1; bus.sclk = 1'b0; cycle(2);
        bus.sclk = 1'b1; cycle(3);
        bus.cs = 1'b0; cycle(2);
        sclk_falls(4, 2);
        bus.cs = 1'b1; bus.sclk = 1'b0; cycle(2);
        bus.sclk = 1'b1; cycle(3);

        // fall_cs together with fall_sclk: that fall is not counted
        bus.mode = 2'd0;
        bus.cs = 1'b0; bus.sclk = 1'b0; cycle(2);
        bus.sclk = 1'b1; cycle(2);
        sclk_falls(FLEN, 2);
        bus.cs = 1'b1; cycle(3);

        // run dropped mid-frame
        bus.cs = 1'b0; cycle(2);
        sclk_falls(5, 2);
        bus.run = 1'b0; cycle(3);
        bus.cs = 1'b1; cycle(2);
        bus.run = 1'b1; cycle(2);

        // reset mid-frame; cs held low so a frame opens on the LFSR seed
        bus.mode = 2'd2;
        bus.cs = 1'b0; cycle(2);
        sclk_falls(5, 2);
        reset_n = 1'b0; cycle(2);
        reset_n = 1'b1; cycle(2);
        sclk_falls(FLEN, 2);
        bus.cs = 1'b1; cycle(2);

        // randomised frames
        for (int i = 0; i < 40; i++) begin
            bus.mode = 2'($urandom_range(0, 3));
            bus.const_val = W'($urandom);
            frame($urandom_range(0, FLEN + 3), $urandom_range(2, 3));
            cycle($urandom_range(1, 4));
        end

        // back-to-back latches sweep triangle turnarounds and LFSR steps
        bus.mode = 2'd1;
        repeat (420) begin
            bus.cs = 1'b0; cycle(1);
            bus.cs = 1'b1; cycle(1);
        end
        bus.mode = 2'd2;
        repeat (60) begin
            bus.cs = 1'b0; cycle(1);
            bus.cs = 1'b1; cycle(1);
        end
        cycle(2);

        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d records left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
